// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle for the sequential shift-add multiplier.
interface shift_add_multiplier_if #(parameter int WIDTH = 8);
  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic                 busy_o;
  logic                 done_o;
  logic [2*WIDTH-1:0]   out_data;

  modport master (output start_i, signed_i, a_i, b_i,
                  input  busy_o, done_o, out_data);
  modport slave  (input  start_i, signed_i, a_i, b_i,
                  output busy_o, done_o, out_data);
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add multiplier, optional two's-complement mode,
// early exit once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  shift_add_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     mcand, acc, out_q;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     cnt;
  logic              neg;

  // Operand conditioning: magnitudes and result sign, valid in the start cycle
  logic              sgn_mode, neg_in;
  logic [WIDTH-1:0]  a_mag, b_mag;
  assign sgn_mode = SIGNED_EN && bus.signed_i;
  assign a_mag    = (sgn_mode && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign b_mag    = (sgn_mode && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
  assign neg_in   = sgn_mode && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);

  // One iteration: conditional add, then check whether any multiplier bits remain
  logic [PW-1:0]     acc_sum;
  logic [WIDTH-1:0]  mplier_sh;
  logic              last;
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);
  assign mplier_sh = mplier >> 1;
  // The counter bound is a backstop only; mplier runs out first
  assign last      = (mplier_sh == '0) || (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = (b_mag == '0) ? DONE : CALC;
      CALC:    if (last)        state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.busy_o   = (state != IDLE);
    bus.done_o   = (state == DONE);
    bus.out_data = out_q;
  end

  // Datapath: capture on accept, iterate in CALC, publish result on entry to DONE
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      out_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          mcand  <= {{WIDTH{1'b0}}, a_mag};
          mplier <= b_mag;
          acc    <= '0;
          cnt    <= '0;
          neg    <= neg_in;
          // zero multiplier skips CALC; result is 0 whatever the sign
          if (b_mag == '0) out_q <= '0;
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + 1'b1;
          if (last) out_q <= neg ? -acc_sum : acc_sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed cases plus random sweep on WIDTH=8 and WIDTH=4.
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(8)) bus8 ();
  shift_add_multiplier_if #(.WIDTH(4)) bus4 ();

  shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (.clk_in(clk), .rst_in(rst), .bus(bus8));
  shift_add_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (.clk_in(clk), .rst_in(rst), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] prev8 = '0, prev4 = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int w, input bit st, input bit s, input logic [7:0] a, input logic [7:0] b);
    if (w == 8) begin
      bus8.start_i = st; bus8.signed_i = s; bus8.a_i = a; bus8.b_i = b;
    end else begin
      bus4.start_i = st; bus4.signed_i = s; bus4.a_i = a[3:0]; bus4.b_i = b[3:0];
    end
  endtask

  task automatic sample(input int w, output logic busy, output logic done, output logic [15:0] out);
    if (w == 8) begin busy = bus8.busy_o; done = bus8.done_o; out = bus8.out_data; end
    else        begin busy = bus4.busy_o; done = bus4.done_o; out = {8'h00, bus4.out_data}; end
  endtask

  // Reference: plain integer multiply of the sign-interpreted operands;
  // latency = bit length of |b|, plus one cycle for DONE
  task automatic ref_mul(input int w, input bit s, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output int lat);
    longint sa, sb, p, mb;
    int n;
    sa = longint'(a) & ((64'd1 << w) - 1);
    sb = longint'(b) & ((64'd1 << w) - 1);
    if (s && sa >= (64'd1 << (w - 1))) sa = sa - (64'd1 << w);
    if (s && sb >= (64'd1 << (w - 1))) sb = sb - (64'd1 << w);
    p    = sa * sb;
    prod = 16'(p & ((64'd1 << (2 * w)) - 1));
    mb   = (sb < 0) ? -sb : sb;
    n    = 0;
    while (mb != 0) begin n++; mb = mb >> 1; end
    lat  = n + 1;
  endtask

  // Issue one job; hold = number of post-start cycles that keep start_i high with junk operands
  task automatic run(input int w, input bit s, input logic [7:0] a, input logic [7:0] b,
                     input int hold, output int lat, output logic [15:0] prod);
    logic busy, done;
    logic [15:0] out, prev;
    prev = (w == 8) ? prev8 : prev4;
    lat  = -1;
    prod = '0;
    @(negedge clk); drive(w, 1'b1, s, a, b);
    @(posedge clk);
    for (int k = 1; k <= w + 3; k++) begin
      @(negedge clk);
      sample(w, busy, done, out);
      if (k <= hold) drive(w, 1'b1, ~s, 8'($urandom), 8'($urandom));
      else           drive(w, 1'b0, s, a, b);
      chk("busy_during_job", busy, 1'b1);
      if (done) begin lat = k; prod = out; break; end
      chk("out_held", out, prev);
    end
    @(negedge clk);
    drive(w, 1'b0, s, a, b);
    sample(w, busy, done, out);
    chk("done_single_pulse", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    chk("out_held_after_done", out, prod);
    if (w == 8) prev8 = prod; else prev4 = prod;
  endtask

  int          lat, elat;
  logic [15:0] prod, eprod;
  logic        busy, done;
  logic [15:0] out;

  initial begin
    rst = 1'b1;
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    sample(8, busy, done, out);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out",  out,  16'h0);
    rst = 1'b0;

    // Directed cases with hand-computed results
    run(8, 1'b0, 8'd13, 8'd11, 0, lat, prod);
    chk("u13x11_lat", lat, 5);   chk("u13x11_out", prod, 16'd143);
    run(8, 1'b1, 8'hFD, 8'h05, 0, lat, prod);
    chk("s-3x5_lat", lat, 4);    chk("s-3x5_out", prod, 16'hFFF1);
    run(8, 1'b1, 8'h80, 8'h80, 0, lat, prod);
    chk("s-128sq_lat", lat, 9);  chk("s-128sq_out", prod, 16'h4000);
    run(8, 1'b0, 8'hFF, 8'hFF, 0, lat, prod);
    chk("u255sq_lat", lat, 9);   chk("u255sq_out", prod, 16'hFE01);
    run(8, 1'b1, 8'hFF, 8'h00, 0, lat, prod);
    chk("bzero_lat", lat, 1);    chk("bzero_out", prod, 16'h0);
    run(8, 1'b0, 8'd7, 8'd1, 0, lat, prod);
    chk("7x1_lat", lat, 2);      chk("7x1_out", prod, 16'd7);
    run(8, 1'b0, 8'd200, 8'd3, 2, lat, prod);
    chk("busy_start_lat", lat, 3); chk("busy_start_out", prod, 16'd600);

    // Reset mid-operation aborts the job asynchronously
    @(negedge clk); drive(8, 1'b1, 1'b0, 8'hFF, 8'hFF);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin @(negedge clk); drive(8, 1'b0, 1'b0, 8'h00, 8'h00); end
    rst = 1'b1;
    #1;
    sample(8, busy, done, out);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_out",  out,  16'h0);
    @(negedge clk); rst = 1'b0;
    prev8 = '0; prev4 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sample(8, busy, done, out);
      chk("no_done_after_abort", done, 1'b0);
    end
    run(8, 1'b0, 8'd2, 8'd2, 0, lat, prod);
    chk("post_abort_lat", lat, 3); chk("post_abort_out", prod, 16'd4);

    // Random sweep over both widths and both modes
    for (int i = 0; i < 120; i++) begin
      int          w;
      bit          s;
      logic [7:0]  a, b;
      w = (i % 2 == 0) ? 8 : 4;
      s = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      ref_mul(w, s, a, b, eprod, elat);
      run(w, s, a, b, int'($urandom_range(0, 2)), lat, prod);
      chk("rand_lat", lat, elat);
      chk("rand_out", prod, eprod);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
